// File: rtl/tennis_score_ctrl.sv
// tennis_score_ctrl: single-game tennis scoring with deuce/advantage handling,
// timed winner display and per-player BCD game counters.
`default_nettype none

module tennis_score_ctrl #(
  parameter int HOLD_CYCLES = 100000000,
  parameter int HOLD_W      = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       point0,
  input  logic       point1,
  input  logic       match_clr,
  output logic [1:0] p0,
  output logic [1:0] p1,
  output logic       squash,
  output logic [1:0] adv,
  output logic       game_pulse,
  output logic [3:0] games0,
  output logic [3:0] games1
);

  typedef enum logic [2:0] {
    PLAY  = 3'd0,
    DEUCE = 3'd1,
    ADV0  = 3'd2,
    ADV1  = 3'd3,
    WIN   = 3'd4
  } state_t;

  localparam logic [1:0] SCORE_40 = 2'b11;

  state_t            state, state_n;
  logic              point0_q, point1_q;
  logic [1:0]        score0, score1, score0_n, score1_n;
  logic              winner, winner_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic [3:0]        games0_n, games1_n;
  logic [1:0]        p0_n, p1_n, adv_n;
  logic              squash_n, game_pulse_n;
  logic              ev0, ev1, only0, only1, enter_win;

  function automatic logic [3:0] bcd_inc(input logic [3:0] v);
    return (v == 4'd9) ? 4'd0 : v + 4'd1;
  endfunction

  // Edge detect against the registered copy so the event acts on the very
  // edge that first samples the button high.
  assign ev0   = point0 & ~point0_q;
  assign ev1   = point1 & ~point1_q;
  assign only0 = ev0 & ~ev1;
  assign only1 = ev1 & ~ev0;

  always_comb begin
    state_n      = state;
    score0_n     = score0;
    score1_n     = score1;
    winner_n     = winner;
    hold_cnt_n   = hold_cnt;
    games0_n     = games0;
    games1_n     = games1;
    enter_win    = 1'b0;
    game_pulse_n = 1'b0;

    if (match_clr) begin
      state_n    = PLAY;
      score0_n   = 2'b00;
      score1_n   = 2'b00;
      winner_n   = 1'b0;
      hold_cnt_n = '0;
      games0_n   = 4'd0;
      games1_n   = 4'd0;
    end else begin
      unique case (state)
        PLAY: begin
          if (only0) begin
            if (score0 != SCORE_40) begin
              score0_n = score0 + 2'd1;
              if (score0_n == SCORE_40 && score1 == SCORE_40) state_n = DEUCE;
            end else begin
              enter_win = 1'b1;
              winner_n  = 1'b0;
            end
          end else if (only1) begin
            if (score1 != SCORE_40) begin
              score1_n = score1 + 2'd1;
              if (score1_n == SCORE_40 && score0 == SCORE_40) state_n = DEUCE;
            end else begin
              enter_win = 1'b1;
              winner_n  = 1'b1;
            end
          end
        end
        DEUCE: begin
          if (only0)      state_n = ADV0;
          else if (only1) state_n = ADV1;
        end
        ADV0: begin
          if (only0) begin
            enter_win = 1'b1;
            winner_n  = 1'b0;
          end else if (only1) begin
            state_n = DEUCE;
          end
        end
        ADV1: begin
          if (only1) begin
            enter_win = 1'b1;
            winner_n  = 1'b1;
          end else if (only0) begin
            state_n = DEUCE;
          end
        end
        WIN: begin
          if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
            state_n    = PLAY;
            score0_n   = 2'b00;
            score1_n   = 2'b00;
            hold_cnt_n = '0;
          end else begin
            hold_cnt_n = hold_cnt + 1'b1;
          end
        end
        default: state_n = PLAY;
      endcase

      if (enter_win) begin
        state_n      = WIN;
        hold_cnt_n   = '0;
        game_pulse_n = 1'b1;
        if (winner_n) games1_n = bcd_inc(games1);
        else          games0_n = bcd_inc(games0);
      end
    end

    // Display values follow the next state so every output is a flop.
    squash_n = (state_n == WIN);
    if (state_n == WIN) begin
      p0_n = winner_n ? 2'b10 : 2'b01;
      p1_n = 2'b00;
    end else begin
      p0_n = score0_n;
      p1_n = score1_n;
    end
    unique case (state_n)
      ADV0:    adv_n = 2'b01;
      ADV1:    adv_n = 2'b10;
      default: adv_n = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PLAY;
      point0_q   <= 1'b0;
      point1_q   <= 1'b0;
      score0     <= 2'b00;
      score1     <= 2'b00;
      winner     <= 1'b0;
      hold_cnt   <= '0;
      games0     <= 4'd0;
      games1     <= 4'd0;
      p0         <= 2'b00;
      p1         <= 2'b00;
      squash     <= 1'b0;
      adv        <= 2'b00;
      game_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      point0_q   <= point0;
      point1_q   <= point1;
      score0     <= score0_n;
      score1     <= score1_n;
      winner     <= winner_n;
      hold_cnt   <= hold_cnt_n;
      games0     <= games0_n;
      games1     <= games1_n;
      p0         <= p0_n;
      p1         <= p1_n;
      squash     <= squash_n;
      adv        <= adv_n;
      game_pulse <= game_pulse_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tennis_score_ctrl.sv
// Directed bench for tennis_score_ctrl with a short winner hold (4 cycles).
`default_nettype none

module tb_tennis_score_ctrl;

  logic       clk, rst, point0, point1, match_clr;
  logic [1:0] p0, p1, adv;
  logic       squash, game_pulse;
  logic [3:0] games0, games1;

  int nvec = 0;
  int miscompares = 0;

  tennis_score_ctrl #(.HOLD_CYCLES(4), .HOLD_W(3)) dut (
    .clk(clk), .rst(rst), .point0(point0), .point1(point1),
    .match_clr(match_clr), .p0(p0), .p1(p1), .squash(squash), .adv(adv),
    .game_pulse(game_pulse), .games0(games0), .games1(games1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected = {p0, p1, squash, adv, game_pulse, games0, games1}
  typedef struct {
    logic        pt0;
    logic        pt1;
    logic        clr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic a, input logic b, input logic c,
                     input logic [1:0] ep0, input logic [1:0] ep1, input logic esq,
                     input logic [1:0] eadv, input logic egp,
                     input logic [3:0] eg0, input logic [3:0] eg1);
    vec_t v;
    v.pt0 = a; v.pt1 = b; v.clr = c;
    v.exp = {ep0, ep1, esq, eadv, egp, eg0, eg1};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {p0, p1, squash, adv, game_pulse, games0, games1};
    nvec++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got p0=%b p1=%b sq=%b adv=%b gp=%b g0=%0d g1=%0d, want p0=%b p1=%b sq=%b adv=%b gp=%b g0=%0d g1=%0d",
               name, act[15:14], act[13:12], act[11], act[10:9], act[8], act[7:4], act[3:0],
               exp[15:14], exp[13:12], exp[11], exp[10:9], exp[8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int pl);
    if (pl == 0) point0 = 1'b1; else point1 = 1'b1;
    tick();
    point0 = 1'b0;
    point1 = 1'b0;
    tick();
  endtask

  // Four edges from 00/00, then the full hold and exit.
  task automatic win_game(input int pl, input logic [3:0] eg0, input logic [3:0] eg1,
                          input string name);
    for (int i = 0; i < 3; i++) press(pl);
    if (pl == 0) point0 = 1'b1; else point1 = 1'b1;
    tick();
    check({name, "_entry"}, {(pl == 0) ? 2'b01 : 2'b10, 2'b00, 1'b1, 2'b00, 1'b1, eg0, eg1});
    point0 = 1'b0;
    point1 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check({name, "_hold"}, {(pl == 0) ? 2'b01 : 2'b10, 2'b00, 1'b1, 2'b00, 1'b0, eg0, eg1});
    tick();
    check({name, "_exit"}, {2'b00, 2'b00, 1'b0, 2'b00, 1'b0, eg0, eg1});
  endtask

  initial begin
    rst = 1'b1; point0 = 1'b0; point1 = 1'b0; match_clr = 1'b0;

    // Player 0 wins to love, then hold of 4 cycles.
    add(1,0,0, 2'b01,2'b00,0,2'b00,0, 4'd0,4'd0);
    add(0,0,0, 2'b01,2'b00,0,2'b00,0, 4'd0,4'd0);
    add(1,0,0, 2'b10,2'b00,0,2'b00,0, 4'd0,4'd0);
    add(0,0,0, 2'b10,2'b00,0,2'b00,0, 4'd0,4'd0);
    add(1,0,0, 2'b11,2'b00,0,2'b00,0, 4'd0,4'd0);
    add(0,0,0, 2'b11,2'b00,0,2'b00,0, 4'd0,4'd0);
    add(1,0,0, 2'b01,2'b00,1,2'b00,1, 4'd1,4'd0);
    add(0,0,0, 2'b01,2'b00,1,2'b00,0, 4'd1,4'd0);
    add(0,0,0, 2'b01,2'b00,1,2'b00,0, 4'd1,4'd0);
    add(0,0,0, 2'b01,2'b00,1,2'b00,0, 4'd1,4'd0);
    add(0,0,0, 2'b00,2'b00,0,2'b00,0, 4'd1,4'd0);
    // Simultaneous edges ignored; a held button counts once.
    add(1,1,0, 2'b00,2'b00,0,2'b00,0, 4'd1,4'd0);
    add(0,0,0, 2'b00,2'b00,0,2'b00,0, 4'd1,4'd0);
    for (int i = 0; i < 10; i++) add(1,0,0, 2'b01,2'b00,0,2'b00,0, 4'd1,4'd0);
    add(0,0,0, 2'b01,2'b00,0,2'b00,0, 4'd1,4'd0);
    // Clear, then the deuce/advantage walk.
    add(0,0,1, 2'b00,2'b00,0,2'b00,0, 4'd0,4'd0);
    add(1,0,0, 2'b01,2'b00,0,2'b00,0, 4'd0,4'd0);
    add(0,0,0, 2'b01,2'b00,0,2'b00,0, 4'd0,4'd0);
    add(0,1,0, 2'b01,2'b01,0,2'b00,0, 4'd0,4'd0);
    add(0,0,0, 2'b01,2'b01,0,2'b00,0, 4'd0,4'd0);
    add(1,0,0, 2'b10,2'b01,0,2'b00,0, 4'd0,4'd0);
    add(0,0,0, 2'b10,2'b01,0,2'b00,0, 4'd0,4'd0);
    add(0,1,0, 2'b10,2'b10,0,2'b00,0, 4'd0,4'd0);
    add(0,0,0, 2'b10,2'b10,0,2'b00,0, 4'd0,4'd0);
    add(1,0,0, 2'b11,2'b10,0,2'b00,0, 4'd0,4'd0);
    add(0,0,0, 2'b11,2'b10,0,2'b00,0, 4'd0,4'd0);
    add(0,1,0, 2'b11,2'b11,0,2'b00,0, 4'd0,4'd0);
    add(0,0,0, 2'b11,2'b11,0,2'b00,0, 4'd0,4'd0);
    add(0,1,0, 2'b11,2'b11,0,2'b10,0, 4'd0,4'd0);
    add(0,0,0, 2'b11,2'b11,0,2'b10,0, 4'd0,4'd0);
    add(1,0,0, 2'b11,2'b11,0,2'b00,0, 4'd0,4'd0);
    add(0,0,0, 2'b11,2'b11,0,2'b00,0, 4'd0,4'd0);
    add(1,0,0, 2'b11,2'b11,0,2'b01,0, 4'd0,4'd0);
    add(0,0,0, 2'b11,2'b11,0,2'b01,0, 4'd0,4'd0);
    add(1,0,0, 2'b01,2'b00,1,2'b00,1, 4'd1,4'd0);
    // Edges during WIN ignored; button held through exit gives no event.
    add(0,1,0, 2'b01,2'b00,1,2'b00,0, 4'd1,4'd0);
    add(0,0,0, 2'b01,2'b00,1,2'b00,0, 4'd1,4'd0);
    add(1,0,0, 2'b01,2'b00,1,2'b00,0, 4'd1,4'd0);
    add(1,0,0, 2'b00,2'b00,0,2'b00,0, 4'd1,4'd0);
    add(1,0,0, 2'b00,2'b00,0,2'b00,0, 4'd1,4'd0);
    add(0,0,0, 2'b00,2'b00,0,2'b00,0, 4'd1,4'd0);

    #12;
    check("reset", 16'h0000);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      point0 = vecs[i].pt0;
      point1 = vecs[i].pt1;
      match_clr = vecs[i].clr;
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
    point0 = 1'b0; point1 = 1'b0; match_clr = 1'b0;

    // Ten player-1 wins: games1 wraps 9 -> 0.
    for (int k = 0; k < 10; k++)
      win_game(1, 4'd1, 4'((k + 1) % 10), $sformatf("p1win%0d", k));

    match_clr = 1'b1;
    tick();
    match_clr = 1'b0;
    check("clr_games", 16'h0000);

    for (int k = 0; k < 3; k++)
      win_game(0, 4'(k + 1), 4'd0, $sformatf("p0win%0d", k));

    for (int i = 0; i < 3; i++) press(0);
    for (int i = 0; i < 3; i++) press(1);
    check("deuce2", {2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 4'd3, 4'd0});
    press(0);
    check("adv0", {2'b11, 2'b11, 1'b0, 2'b01, 1'b0, 4'd3, 4'd0});
    point0 = 1'b1;
    match_clr = 1'b1;
    tick();
    check("clr_over_event", 16'h0000);
    point0 = 1'b0;
    match_clr = 1'b0;
    tick();
    check("clr_settled", 16'h0000);

    // Asynchronous reset mid-WIN, with point1 high across the release.
    for (int i = 0; i < 3; i++) press(0);
    point0 = 1'b1;
    tick();
    check("pre_rst_win", {2'b01, 2'b00, 1'b1, 2'b00, 1'b1, 4'd1, 4'd0});
    point0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst", 16'h0000);
    point1 = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    check("held_at_release", {2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 4'd0, 4'd0});
    point1 = 1'b0;
    tick();
    check("after_release", {2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 4'd0, 4'd0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
